// File: rtl/sockit_spi_pkg.sv
// Shared constants and types for the SPI datapath blocks.
package sockit_spi_pkg;

  localparam int unsigned SPI_DW         = 32;
  localparam int unsigned SPI_FIFO_DEPTH = 4;

  // Occupancy count for the default-depth FIFO (0..SPI_FIFO_DEPTH inclusive).
  typedef logic [$clog2(SPI_FIFO_DEPTH):0] spi_fifo_cnt_t;

endpackage

// File: rtl/sockit_spi_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module sockit_spi_fifo_mem
  import sockit_spi_pkg::*;
#(
  parameter int unsigned DW    = SPI_DW,
  parameter int unsigned DEPTH = SPI_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdat
);

  // Storage is intentionally not reset; contents are qualified by the pointers.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/sockit_spi_fifo.sv
// Synchronous vld/rdy decoupling FIFO for the SPI datapath.
// Define SOCKIT_SPI_FIFO_BYPASS_EN for a zero-latency pass-through when empty.
module sockit_spi_fifo
  import sockit_spi_pkg::*;
#(
  parameter int unsigned DW    = SPI_DW,
  parameter int unsigned DEPTH = SPI_FIFO_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  input  logic          out_rdy,
  output logic [CW-1:0] cnt
);

  localparam int unsigned AW = CW - 1;

  logic [CW-1:0] wp;
  logic [CW-1:0] rp;
  logic          ena;
  logic          empty;
  logic          full;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] mem_dat;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty  = (wp == rp);
  assign full   = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign in_rdy = ena & ~full;
  assign cnt    = wp - rp;
  assign rd_en  = ~empty & out_rdy & ~clr;

`ifdef SOCKIT_SPI_FIFO_BYPASS_EN
  logic byp;

  // An empty FIFO forwards the incoming word; it is only stored if not taken.
  assign byp     = empty & in_vld & ena & ~clr;
  assign out_vld = ~empty | byp;
  assign out_dat = byp ? in_dat : mem_dat;
  assign wr_en   = in_vld & in_rdy & ~clr & ~(byp & out_rdy);
`else
  assign out_vld = ~empty;
  assign out_dat = mem_dat;
  assign wr_en   = in_vld & in_rdy & ~clr;
`endif

  // ena holds off transfers until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      ena <= 1'b0;
    end else begin
      ena <= 1'b1;
      if (clr) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr_en) wp <= wp + CW'(1);
        if (rd_en) rp <= rp + CW'(1);
      end
    end
  end

  sockit_spi_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp[AW-1:0]),
    .wdat  (in_dat),
    .raddr (rp[AW-1:0]),
    .rdat  (mem_dat)
  );

endmodule
